// File: rtl/multicycle_main_controller_if.sv
// Control bundle between the multicycle main controller and the MIPS datapath.
// The controller takes the master side; the datapath/IR side takes the slave side.
interface multicycle_main_controller_if;
  logic [5:0] Op;
  logic       Zero;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic       Branch;
  logic       PCWrite;
  logic       PCEn;
  logic [3:0] State;

  modport master (
    input  Op, Zero,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, PCSrc, Branch, PCWrite, PCEn, State
  );

  modport slave (
    output Op, Zero,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
           ALUSrcB, ALUOp, PCSrc, Branch, PCWrite, PCEn, State
  );
endinterface

// File: rtl/multicycle_main_controller.sv
// Moore FSM sequencing the shared multicycle MIPS datapath; PCEn is the only
// output that also depends on an input (Zero).
module multicycle_main_controller (
  input  logic                                clk,
  input  logic                                reset,
  multicycle_main_controller_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_e state_q, state_d;
  state_e out_state;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  // During reset the selects show FETCH values and every enable is held low.
  always_comb begin
    out_state    = reset ? S_FETCH : state_q;
    bus.IorD     = 1'b0;
    bus.MemWrite = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.RegDst   = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA  = 1'b0;
    bus.ALUSrcB  = '0;
    bus.ALUOp    = '0;
    bus.PCSrc    = '0;
    bus.Branch   = 1'b0;
    bus.PCWrite  = 1'b0;
    case (out_state)
      S_FETCH: begin
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
        bus.ALUSrcB = 2'b01;
      end
      S_DECODE:  bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD:   bus.IorD = 1'b1;
      S_MEMWB: begin
        bus.MemtoReg = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_MEMWR: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        bus.RegDst   = 1'b1;
        bus.RegWrite = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b01;
        bus.PCSrc   = 2'b01;
        bus.Branch  = 1'b1;
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB:  bus.RegWrite = 1'b1;
      S_JUMP: begin
        bus.PCSrc   = 2'b10;
        bus.PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      bus.IRWrite = 1'b0;
      bus.PCWrite = 1'b0;
    end
  end

  assign bus.PCEn  = bus.PCWrite | (bus.Branch & bus.Zero);
  assign bus.State = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Bench for the multicycle main controller: instruction vectors, hand-written
// reset corner cases and random instruction streams against a path/table model.
module tb_multicycle_main_controller;

  logic clk = 1'b0;
  logic reset;
  int unsigned checks = 0;
  int unsigned errors = 0;

  multicycle_main_controller_if bus ();

  multicycle_main_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Control word: {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //                ALUSrcB[1:0],ALUOp[1:0],PCSrc[1:0],Branch,PCWrite}
  logic [14:0] ctrl_tab [12];
  localparam logic [14:0] CTRL_RESET = 15'b000_000_0_01_00_00_0_0;

  typedef struct {
    logic [5:0]  op;
    int unsigned zmode;   // 0: Zero low, 1: Zero high, 2: random
    int unsigned lat;
  } vec_t;
  vec_t vecs[8];

  function automatic logic [14:0] dut_ctrl();
    return {bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg,
            bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc,
            bus.Branch, bus.PCWrite};
  endfunction

  // Expected state path of one instruction, FETCH included.
  function automatic void model_path(input logic [5:0] op, output int unsigned p[$]);
    p = {};
    p.push_back(0);
    p.push_back(1);
    case (op)
      6'b100011: begin p.push_back(2); p.push_back(3); p.push_back(4); end
      6'b101011: begin p.push_back(2); p.push_back(5); end
      6'b000000: begin p.push_back(6); p.push_back(7); end
      6'b000100: p.push_back(8);
      6'b001000: begin p.push_back(9); p.push_back(10); end
      6'b000010: p.push_back(11);
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cycle(input int unsigned exp_state, input logic rst);
    logic [14:0] exp_ctrl;
    logic        exp_pcen;
    exp_ctrl = rst ? CTRL_RESET : ctrl_tab[exp_state];
    exp_pcen = exp_ctrl[0] | (exp_ctrl[1] & bus.Zero);
    checks++;
    if (bus.State !== exp_state[3:0]) begin
      errors++;
      $display("FAIL state: got %0d expected %0d (t=%0t)", bus.State, exp_state, $time);
    end
    checks++;
    if (dut_ctrl() !== exp_ctrl) begin
      errors++;
      $display("FAIL ctrl: state %0d got %b expected %b (t=%0t)", exp_state, dut_ctrl(), exp_ctrl, $time);
    end
    checks++;
    if (bus.PCEn !== exp_pcen) begin
      errors++;
      $display("FAIL pcen: state %0d zero %b got %b expected %b", exp_state, bus.Zero, bus.PCEn, exp_pcen);
    end
  endtask

  // Runs one instruction from FETCH; returns cycles until State is back at FETCH.
  task automatic run_instr(input logic [5:0] op, input int unsigned zmode, output int unsigned cycles);
    int unsigned p[$];
    model_path(op, p);
    cycles = 0;
    do begin
      bus.Op   = op;
      bus.Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      #1;
      if (cycles < p.size()) check_cycle(p[cycles], 1'b0);
      cycles++;
      @(posedge clk);
      #1;
    end while (bus.State != 4'd0 && cycles < 12);
  endtask

  task automatic check_latency(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL latency %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int unsigned cyc;
    logic [5:0]  ops [6];

    ctrl_tab[0]  = 15'b001_000_0_01_00_00_0_1;
    ctrl_tab[1]  = 15'b000_000_0_11_00_00_0_0;
    ctrl_tab[2]  = 15'b000_000_1_10_00_00_0_0;
    ctrl_tab[3]  = 15'b100_000_0_00_00_00_0_0;
    ctrl_tab[4]  = 15'b000_011_0_00_00_00_0_0;
    ctrl_tab[5]  = 15'b110_000_0_00_00_00_0_0;
    ctrl_tab[6]  = 15'b000_000_1_00_10_00_0_0;
    ctrl_tab[7]  = 15'b000_101_0_00_00_00_0_0;
    ctrl_tab[8]  = 15'b000_000_1_00_01_01_1_0;
    ctrl_tab[9]  = 15'b000_000_1_10_00_00_0_0;
    ctrl_tab[10] = 15'b000_001_0_00_00_00_0_0;
    ctrl_tab[11] = 15'b000_000_0_00_00_10_0_1;

    vecs[0] = '{op: 6'b100011, zmode: 0, lat: 5};
    vecs[1] = '{op: 6'b101011, zmode: 1, lat: 4};
    vecs[2] = '{op: 6'b000000, zmode: 0, lat: 4};
    vecs[3] = '{op: 6'b001000, zmode: 1, lat: 4};
    vecs[4] = '{op: 6'b000100, zmode: 1, lat: 3};
    vecs[5] = '{op: 6'b000100, zmode: 0, lat: 3};
    vecs[6] = '{op: 6'b000010, zmode: 0, lat: 3};
    vecs[7] = '{op: 6'b111111, zmode: 1, lat: 2};

    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

    // Power-up reset for two edges.
    reset = 1'b1;
    bus.Op = '0;
    bus.Zero = 1'b0;
    tick();
    tick();
    check_cycle(0, 1'b1);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].zmode, cyc);
      check_latency($sformatf("vec%0d op=%b", i, vecs[i].op), cyc, vecs[i].lat);
    end

    // Reset while parked in ALUWB, held for two cycles.
    bus.Op = 6'b000000;
    bus.Zero = 1'b1;
    #1 check_cycle(0, 1'b0);
    tick();
    #1 check_cycle(1, 1'b0);
    tick();
    #1 check_cycle(6, 1'b0);
    tick();
    #1 check_cycle(7, 1'b0);
    reset = 1'b1;
    #1 check_cycle(7, 1'b1);
    tick();
    #1 check_cycle(0, 1'b1);
    tick();
    #1 check_cycle(0, 1'b1);
    reset = 1'b0;
    bus.Zero = 1'b0;
    run_instr(6'b100011, 0, cyc);
    check_latency("lw after reset", cyc, 5);

    // One-cycle reset in MEMRD drops the lw before its write-back.
    bus.Op = 6'b100011;
    #1 check_cycle(0, 1'b0);
    tick();
    #1 check_cycle(1, 1'b0);
    tick();
    #1 check_cycle(2, 1'b0);
    tick();
    #1 check_cycle(3, 1'b0);
    reset = 1'b1;
    #1 check_cycle(3, 1'b1);
    tick();
    reset = 1'b0;
    run_instr(6'b100011, 2, cyc);
    check_latency("lw after mid reset", cyc, 5);

    // Random instruction stream with random Zero.
    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      int unsigned exp_lat;
      int unsigned p[$];
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 5)];
      model_path(op, p);
      exp_lat = p.size();
      run_instr(op, 2, cyc);
      check_latency($sformatf("rand%0d op=%b", n, op), cyc, exp_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit %0d ns", 200000);
    $fatal(1);
  end

endmodule
